// File: rtl/serial_rx_top.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at mid-bit
// and presents the received byte on d_out with a one-cycle done strobe.
module serial_rx_top #(
   parameter int unsigned CLKS_PER_BIT = 35,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_data,
   output logic                 done,
   output logic [DATA_BITS-1:0] d_out
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t               state, state_next;
   logic                 sync_q1, rx_s;
   logic [CNT_W-1:0]     clk_cnt, cnt_next;
   logic [BIT_W-1:0]     bit_idx, bit_next;
   logic [DATA_BITS-1:0] shift_q, shift_next;
   logic [DATA_BITS-1:0] dout_next;
   logic                 done_next;

   // Two-flop synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync_q1 <= s_data;
         rx_s    <= sync_q1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift_q <= '0;
         d_out   <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         clk_cnt <= cnt_next;
         bit_idx <= bit_next;
         shift_q <= shift_next;
         d_out   <= dout_next;
         done    <= done_next;
      end
   end

   // Phase timing: START lasts half a bit, DATA/STOP a full bit each
   always_comb begin
      state_next = state;
      cnt_next   = clk_cnt;
      bit_next   = bit_idx;
      shift_next = shift_q;
      dout_next  = d_out;
      done_next  = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            if (clk_cnt == HALF_LAST) begin
               cnt_next   = '0;
               bit_next   = '0;
               state_next = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (clk_cnt == FULL_LAST) begin
               cnt_next            = '0;
               shift_next[bit_idx] = rx_s;
               if (bit_idx == BIT_LAST) state_next = S_STOP;
               else                     bit_next   = bit_idx + BIT_W'(1);
            end else begin
               cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (clk_cnt == FULL_LAST) begin
               cnt_next = '0;
               // A low stop bit is a framing error: drop the byte silently
               if (rx_s) begin
                  dout_next  = shift_q;
                  done_next  = 1'b1;
                  state_next = S_DONE;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_rx_top.sv
// Directed bench for serial_rx_top: frames driven at a 2760 ns bit period
// against a 12.5 MHz clock, expected bytes computed by hand.
`timescale 1ns/1ps
module tb_serial_rx_top;

   localparam int BIT_NS = 2760;

   logic       clk;
   logic       reset;
   logic       s_data;
   logic       done;
   logic [7:0] d_out;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   serial_rx_top dut (
      .clk    (clk),
      .reset  (reset),
      .s_data (s_data),
      .done   (done),
      .d_out  (d_out)
   );

   initial clk = 1'b0;
   always #40 clk = ~clk;

   // Counts cycles with done high, so a stretched strobe shows up as extra pulses
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic send_frame(input logic [7:0] b, input logic stop);
      s_data = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         s_data = b[i];
         #(BIT_NS);
      end
      s_data = stop;
      #(BIT_NS);
      s_data = 1'b1;
      #(BIT_NS * 3);
   endtask

   task automatic test_reset;
      s_data = 1'b1;
      reset  = 1'b1;
      #100;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (d_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", d_out); end
      reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== 0) begin errors++; $display("FAIL idle_quiet pulses=%0d exp=0", done_cnt); end
   endtask

   // Start aligned just after a clock edge so the latency count is exact
   task automatic test_first_frame;
      int base;
      int n;
      logic [6:0] bits;
      bits = 7'b0100110;
      base = done_cnt;
      n = 0;
      @(posedge clk); #1;
      fork
         begin
            s_data = 1'b0;
            #(BIT_NS);
            for (int i = 0; i < 7; i++) begin
               s_data = bits[i];
               #(BIT_NS);
            end
            s_data = 1'b1;
         end
         begin
            while (done !== 1'b1 && n < 400) begin
               @(posedge clk); #2;
               n++;
            end
         end
      join
      checks++;
      if (n !== 335) begin errors++; $display("FAIL latency got=%0d exp=335", n); end
      checks++;
      if (d_out !== 8'hA6) begin errors++; $display("FAIL a6_dout got=%h exp=a6", d_out); end
      #(BIT_NS * 6);
      checks++;
      if (done_cnt - base !== 1) begin errors++; $display("FAIL a6_pulses got=%0d exp=1", done_cnt - base); end
      checks++;
      if (d_out !== 8'hA6) begin errors++; $display("FAIL a6_hold got=%h exp=a6", d_out); end
   endtask

   task automatic test_back_to_back;
      int base;
      base = done_cnt;
      send_frame(8'h55, 1'b1);
      checks++;
      if (done_cnt - base !== 1) begin errors++; $display("FAIL f55_pulses got=%0d exp=1", done_cnt - base); end
      checks++;
      if (d_out !== 8'h55) begin errors++; $display("FAIL f55_dout got=%h exp=55", d_out); end
      send_frame(8'hFF, 1'b1);
      checks++;
      if (done_cnt - base !== 2) begin errors++; $display("FAIL fff_pulses got=%0d exp=2", done_cnt - base); end
      checks++;
      if (d_out !== 8'hFF) begin errors++; $display("FAIL fff_dout got=%h exp=ff", d_out); end
   endtask

   task automatic test_glitch;
      int base;
      base = done_cnt;
      @(posedge clk); #1;
      s_data = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      s_data = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - base !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", done_cnt - base); end
      checks++;
      if (d_out !== 8'hFF) begin errors++; $display("FAIL glitch_dout got=%h exp=ff", d_out); end
   endtask

   task automatic test_framing_error;
      int base;
      base = done_cnt;
      send_frame(8'h3C, 1'b0);
      #(BIT_NS * 12);
      checks++;
      if (done_cnt - base !== 0) begin errors++; $display("FAIL ferr_pulses got=%0d exp=0", done_cnt - base); end
      checks++;
      if (d_out !== 8'hFF) begin errors++; $display("FAIL ferr_dout got=%h exp=ff", d_out); end
      send_frame(8'h81, 1'b1);
      checks++;
      if (done_cnt - base !== 1) begin errors++; $display("FAIL f81_pulses got=%0d exp=1", done_cnt - base); end
      checks++;
      if (d_out !== 8'h81) begin errors++; $display("FAIL f81_dout got=%h exp=81", d_out); end
   endtask

   // Frame 8'hF3 cut during bit 4; the remaining bits are all high
   task automatic test_reset_mid_frame;
      int base;
      logic [7:0] b;
      b = 8'hF3;
      base = done_cnt;
      s_data = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         s_data = b[i];
         #(BIT_NS);
      end
      s_data = 1'b1;
      #(BIT_NS / 2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (d_out !== 8'h00) begin errors++; $display("FAIL midrst_dout got=%h exp=00", d_out); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
      @(posedge clk); #1;
      reset = 1'b0;
      #(BIT_NS * 8);
      checks++;
      if (done_cnt - base !== 0) begin errors++; $display("FAIL midrst_pulses got=%0d exp=0", done_cnt - base); end
      send_frame(8'h5A, 1'b1);
      checks++;
      if (done_cnt - base !== 1) begin errors++; $display("FAIL f5a_pulses got=%0d exp=1", done_cnt - base); end
      checks++;
      if (d_out !== 8'h5A) begin errors++; $display("FAIL f5a_dout got=%h exp=5a", d_out); end
   endtask

   initial begin
      reset  = 1'b1;
      s_data = 1'b1;
      test_reset();
      test_first_frame();
      test_back_to_back();
      test_glitch();
      test_framing_error();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
